imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the 256-byte instruction memory. Accepts a byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit instruction words, and writes them to consecutive word addresses starting at 0x00. Holds the processor in reset until a complete, valid image is loaded, then releases it so the program counter starts fetching at 0x00.

## Interface
- `ADDR_W`, 8: byte-address width of instruction memory.
- `MAX_WORDS`, 64: largest accepted image in words (256 bytes / 4).

- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous reset, active-high.
- `start`  in  1  single-cycle pulse; restarts a load from DONE or ERROR.
- `in_valid`  in  1  `in_data` holds a byte.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `im_we`  out  1  instruction-memory write strobe, one cycle per word.
- `im_addr`  out  ADDR_W  byte address of write, always a multiple of 4.
- `im_wdata`  out  32  instruction word.
- `cpu_reset`  out  1  drives the program counter reset; high while loading.
- `done`  out  1  image loaded and accepted.
- `error`  out  1  image rejected.

## Operation
- Stream format: length byte N (words), then 4·N data bytes, most-significant byte first; optional checksum byte (see Configuration).
- States: LEN, DATA, CSUM, DONE, ERROR. Reset state LEN.
- LEN: on accept, N=0 or N>MAX_WORDS → ERROR; otherwise store N, clear word index and byte counter → DATA.
- DATA: each accepted byte shifts into the word register. On the 4th byte of a word: register `im_wdata`, `im_addr` = index·4, `im_we`=1 for the next cycle; increment index. After word N → CSUM (macro on) or DONE.
- DONE: `in_ready`=0, `done`=1. `start` → LEN.
- ERROR: `in_ready`=0, `error`=1, `cpu_reset` stays 1. `start` → LEN.
- `start` in LEN, DATA or CSUM is ignored.
- Byte accepted iff `in_valid && in_ready`. `in_ready`=1 in LEN, DATA, CSUM, including during a pending write.
- Memory contents are never cleared; words beyond N keep old values.

## Timing
- Reset values: `in_ready`=1, `im_we`=0, `im_addr`=0, `im_wdata`=0, `cpu_reset`=1, `done`=0, `error`=0.
- Write latency: 4th byte accepted at edge k → `im_we` high from k to k+1; memory captures at k+1.
- `done`/`error` follow the state register: high the cycle after the deciding byte is accepted.
- `cpu_reset` registered from state: falls one edge after DONE is entered, guaranteeing the last write has landed. It re-asserts the edge after `start` is taken from DONE.
- Bubbles on `in_valid` stall progress without effect on data.
- Reset mid-load: partial word discarded, counters cleared, `im_we` forced 0 on the same edge.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: after the last data byte, enter CSUM. Accept one byte and compare it to the XOR of all data bytes (length byte excluded). Match → DONE; mismatch → ERROR.
- Not defined: CSUM state and XOR accumulator are absent; the last data byte → DONE.

## Structure
- `imem_loader_pkg`: state encoding, `MAX_WORDS`, `BYTES_PER_WORD`=4.
- Sub-module `word_packer`: 2-bit byte counter plus 32-bit shift register with a `word_valid` pulse. The FSM, address counter and reset control stay in `imem_loader`.

## Test plan
- Bytes 02, 20 08 00 05, 20 09 00 07 (macro off) → `im_we` at addr 0x00 with data 0x20080005, then addr 0x04 with data 0x20090007. `done`=1, then `cpu_reset` falls one cycle later.
- Length byte 00, and separately 41 → `error`=1, `in_ready`=0, no `im_we`, `cpu_reset` stays 1.
- Same two-word image with random `in_valid` gaps → identical writes and addresses.
- Macro on, same image plus checksum 03 → DONE. Plus checksum 04 → ERROR, `cpu_reset` stays 1.
- `reset` after 3 bytes of word 0, then the full image → first write at 0x00 with the correct word; no stray `im_we`.
- `start` pulse in DONE → `cpu_reset`=1 next cycle, `done`=0, `in_ready`=1. A new one-word image writes to 0x00.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and sizing constants for the instruction-memory loader.
// Rev 1.0
`default_nettype none

package imem_loader_pkg;

   localparam int MAX_WORDS      = 64;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      S_LEN   = 3'd0,
      S_DATA  = 3'd1,
      S_CSUM  = 3'd2,
      S_DONE  = 3'd3,
      S_ERROR = 3'd4
   } state_e;

endpackage

`default_nettype wire

// File: rtl/imem_loader_word_packer.sv
// word_packer: byte counter plus shift register; presents the big-endian word combinationally with its 4th byte.
// Rev 1.0
`default_nettype none

module word_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic        word_valid,
   output logic [31:0] word
);
   import imem_loader_pkg::*;

   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] sh_q, sh_d;

   // Only the first three bytes need storage; the 4th is taken straight from the input.
   assign word_valid = byte_valid && (cnt_q == 2'(BYTES_PER_WORD - 1));
   assign word       = {sh_q, byte_in};

   always_comb begin
      cnt_d = cnt_q;
      sh_d  = sh_q;
      if (clr) begin
         cnt_d = '0;
         sh_d  = '0;
      end else if (byte_valid) begin
         cnt_d = cnt_q + 2'd1;
         sh_d  = {sh_q[15:0], byte_in};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         sh_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         sh_q  <= sh_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed image into instruction memory and holds the CPU in reset until done.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined. Rev 1.0
`default_nettype none

module imem_loader #(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = imem_loader_pkg::MAX_WORDS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error
);
   import imem_loader_pkg::*;

   localparam int         CNT_W   = $clog2(MAX_WORDS + 1);
   localparam logic [7:0] MAX_LEN = 8'(MAX_WORDS);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic [CNT_W-1:0]   idx_q, idx_d;
   logic               im_we_q, im_we_d;
   logic [ADDR_W-1:0]  im_addr_q, im_addr_d;
   logic [31:0]        im_wdata_q, im_wdata_d;
   logic               cpu_reset_q, cpu_reset_d;
   logic               accept, pk_clr, pk_valid, word_valid;
   logic [31:0]        word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]         csum_q, csum_d;
`endif

   assign in_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
   assign accept   = in_valid && in_ready;
   assign pk_clr   = accept && (state_q == S_LEN);
   assign pk_valid = accept && (state_q == S_DATA);

   word_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clr        (pk_clr),
      .byte_valid (pk_valid),
      .byte_in    (in_data),
      .word_valid (word_valid),
      .word       (word)
   );

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      idx_d      = idx_q;
      im_we_d    = 1'b0;
      im_addr_d  = im_addr_q;
      im_wdata_d = im_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      case (state_q)
         S_LEN: begin
            if (accept) begin
               if ((in_data == 8'd0) || (in_data > MAX_LEN)) begin
                  state_d = S_ERROR;
               end else begin
                  len_d   = in_data[CNT_W-1:0];
                  idx_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_d  = '0;
`endif
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ in_data;
`endif
               if (word_valid) begin
                  im_we_d    = 1'b1;
                  im_addr_d  = ADDR_W'({idx_q, 2'b00});
                  im_wdata_d = word;
                  idx_d      = idx_q + CNT_W'(1);
                  if (idx_q + CNT_W'(1) == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state_d = S_CSUM;
`else
                     state_d = S_DONE;
`endif
                  end
               end
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (accept) begin
               state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
            end
         end
`endif
         S_DONE, S_ERROR: begin
            if (start) state_d = S_LEN;
         end
         default: state_d = S_LEN;
      endcase
      // Released only after a full cycle in DONE, so the final write has landed; re-asserted with start.
      cpu_reset_d = !((state_q == S_DONE) && (state_d == S_DONE));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_LEN;
         len_q       <= '0;
         idx_q       <= '0;
         im_we_q     <= 1'b0;
         im_addr_q   <= '0;
         im_wdata_q  <= '0;
         cpu_reset_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         im_we_q     <= im_we_d;
         im_addr_q   <= im_addr_d;
         im_wdata_q  <= im_wdata_d;
         cpu_reset_q <= cpu_reset_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   assign im_we     = im_we_q;
   assign im_addr   = im_addr_q;
   assign im_wdata  = im_wdata_q;
   assign cpu_reset = cpu_reset_q;
   assign done      = (state_q == S_DONE);
   assign error     = (state_q == S_ERROR);

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table vectors plus hand sequences; expected writes queued and matched on im_we.
// Rev 1.0
`default_nettype none

module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset, start, in_valid;
   logic [7:0]  in_data;
   logic        in_ready, im_we, cpu_reset, done, error;
   logic [7:0]  im_addr;
   logic [31:0] im_wdata;

   imem_loader dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .im_we     (im_we),
      .im_addr   (im_addr),
      .im_wdata  (im_wdata),
      .cpu_reset (cpu_reset),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   logic [39:0] sbq[$];
   logic [39:0] mon_e;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && im_we) begin
         if (sbq.size() == 0) begin
            chk("stray_we", 32'd1, 32'd0);
         end else begin
            mon_e = sbq.pop_front();
            chk("wr_addr", {24'd0, im_addr}, {24'd0, mon_e[39:32]});
            chk("wr_data", im_wdata, mon_e[31:0]);
         end
      end
   end

   task automatic push(input logic [7:0] a, input logic [31:0] d);
      sbq.push_back({a, d});
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; start = 1'b0; in_data = 8'h00;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input bit gaps);
      int g;
      int t;
      g = gaps ? int'($urandom_range(0, 3)) : 0;
      repeat (g) begin in_valid = 1'b0; @(posedge clk); #1; end
      in_valid = 1'b1; in_data = b;
      t = 0;
      while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
      if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic check_end(input bit ed, input bit ee);
      chk("done", {31'd0, done}, {31'd0, ed});
      chk("error", {31'd0, error}, {31'd0, ee});
      chk("in_ready_end", {31'd0, in_ready}, {31'd0, !(ed || ee)});
      chk("cpu_reset_hold", {31'd0, cpu_reset}, 32'd1);
      @(posedge clk); #1;
      chk("cpu_reset_after", {31'd0, cpu_reset}, {31'd0, !ed});
      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", sbq.size(), 32'd0);
   endtask

   typedef struct {
      logic [7:0]  b [10];
      int          n;
      bit          gaps;
      logic [7:0]  cs;
      int          nw;
      logic [31:0] w0, w1;
      bit          ed, ee;
   } vec_t;

   vec_t v [5];

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      v[0] = '{b: '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07, 8'h00},
               n: 9, gaps: 1'b0, cs: 8'h03, nw: 2, w0: 32'h20080005, w1: 32'h20090007, ed: 1'b1, ee: 1'b0};
      v[1] = '{b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               n: 1, gaps: 1'b0, cs: 8'h00, nw: 0, w0: 32'h0, w1: 32'h0, ed: 1'b0, ee: 1'b1};
      v[2] = '{b: '{8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               n: 1, gaps: 1'b0, cs: 8'h00, nw: 0, w0: 32'h0, w1: 32'h0, ed: 1'b0, ee: 1'b1};
      v[3] = v[0];
      v[3].gaps = 1'b1;
      v[4] = '{b: '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               n: 5, gaps: 1'b0, cs: 8'h22, nw: 1, w0: 32'hDEADBEEF, w1: 32'h0, ed: 1'b1, ee: 1'b0};

      do_reset();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_im_we", {31'd0, im_we}, 32'd0);
      chk("rst_im_addr", {24'd0, im_addr}, 32'd0);
      chk("rst_im_wdata", im_wdata, 32'd0);
      chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_error", {31'd0, error}, 32'd0);

      for (int i = 0; i < 5; i++) begin
         do_reset();
         if (v[i].nw > 0) push(8'h00, v[i].w0);
         if (v[i].nw > 1) push(8'h04, v[i].w1);
         for (int j = 0; j < v[i].n; j++) send(v[i].b[j], v[i].gaps);
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (v[i].ed) send(v[i].cs, v[i].gaps);
`endif
         check_end(v[i].ed, v[i].ee);
      end

      // Reset lands on the same edge as the 4th byte of word 0: that write must not appear.
      do_reset();
      send(8'h02, 1'b0); send(8'h20, 1'b0); send(8'h08, 1'b0); send(8'h00, 1'b0);
      in_valid = 1'b1; in_data = 8'h05; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0;
      chk("midrst_we", {31'd0, im_we}, 32'd0);
      chk("midrst_ready", {31'd0, in_ready}, 32'd1);
      push(8'h00, 32'h20080005);
      push(8'h04, 32'h20090007);
      for (int j = 0; j < 9; j++) send(v[0].b[j], 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h03, 1'b0);
`endif
      check_end(1'b1, 1'b0);

      // Restart from DONE and load a one-word image.
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("restart_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("restart_done", {31'd0, done}, 32'd0);
      chk("restart_ready", {31'd0, in_ready}, 32'd1);
      push(8'h00, 32'h11223344);
      send(8'h01, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h44, 1'b0);
`endif
      check_end(1'b1, 1'b0);

      // start while in DATA has no effect.
      do_reset();
      push(8'h00, 32'hAABBCCDD);
      send(8'h01, 1'b0); send(8'hAA, 1'b0);
      start = 1'b1;
      send(8'hBB, 1'b0);
      start = 1'b0;
      chk("start_ign_ready", {31'd0, in_ready}, 32'd1);
      chk("start_ign_done", {31'd0, done}, 32'd0);
      send(8'hCC, 1'b0); send(8'hDD, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h00, 1'b0);
`endif
      check_end(1'b1, 1'b0);

      // Largest image: 64 words, last write at 0xFC.
      do_reset();
      for (int i = 0; i < 64; i++)
         push(8'(4 * i), {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)});
      send(8'h40, 1'b0);
      for (int j = 0; j < 256; j++) send(8'(j), 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h00, 1'b0);
`endif
      check_end(1'b1, 1'b0);

      // ERROR is left only by start.
      do_reset();
      send(8'h00, 1'b0);
      chk("err_state", {31'd0, error}, 32'd1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("err_restart_ready", {31'd0, in_ready}, 32'd1);
      chk("err_restart_error", {31'd0, error}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      do_reset();
      push(8'h00, 32'h20080005);
      push(8'h04, 32'h20090007);
      for (int j = 0; j < 9; j++) send(v[0].b[j], 1'b0);
      send(8'h04, 1'b0);
      check_end(1'b0, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
